// File: rtl/mure_pkg.sv
// Shared constants, trap-type encoding and flag helpers for the multiple-retirement serializer.
package mure_pkg;

   localparam int CAUSE_LEN = 5;
   localparam int PRIV_LEN  = 2;
   localparam int ITYPE_LEN = 3;

   function automatic int iretire_len(input int nret);
      return $clog2(2 * nret + 1) + 1;
   endfunction

   typedef enum logic [ITYPE_LEN-1:0] {
      ITYPE_STD  = 3'd0,
      ITYPE_EXC  = 3'd1,
      ITYPE_INT  = 3'd2,
      ITYPE_ERET = 3'd3
   } itype_e;

   typedef struct packed {
      logic interrupt;
      logic exception;
      logic eret;
   } trap_flags_t;

   // Interrupt outranks exception, which outranks eret.
   function automatic itype_e flags_to_itype(input trap_flags_t f);
      if (f.interrupt) return ITYPE_INT;
      if (f.exception) return ITYPE_EXC;
      if (f.eret)      return ITYPE_ERET;
      return ITYPE_STD;
   endfunction

endpackage

// File: rtl/fifo_v3.sv
// Row FIFO: registered storage with combinational head read; pushes while full are ignored.
module fifo_v3 #(
   parameter int  DEPTH = 16,
   parameter type dtype = logic
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic full_o,
   output logic empty_o,
   input  dtype data_i,
   input  logic push_i,
   output dtype data_o,
   input  logic pop_i
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   dtype          mem_q [DEPTH];
   dtype          mem_d [DEPTH];
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      mem_d    = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop) cnt_d = cnt_q + (AW+1)'(1);
      else if (!do_push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/mure_slot_picker.sv
// Finds the next valid slot at/after the pointer and the extent of its beat.
// MURE_MERGE_EN: extend the beat over following valid slots with sequential PCs.
module mure_slot_picker #(
   parameter int NRET        = 2,
   parameter int XLEN        = 64,
   parameter int IDX_W       = 1,
   parameter int IRETIRE_LEN = 4
) (
   input  logic [NRET-1:0]        valid_i,
   input  logic [NRET*XLEN-1:0]   pc_i,
   input  logic [NRET-1:0]        compressed_i,
   input  logic [IDX_W-1:0]       ptr_i,
   output logic                   found_o,
   output logic [XLEN-1:0]        iaddr_o,
   output logic [IRETIRE_LEN-1:0] iretire_o,
   output logic                   ilastsize_o,
   output logic                   last_o,
   output logic [IDX_W-1:0]       next_ptr_o
);

   int   end_idx;
   logic more;
`ifdef MURE_MERGE_EN
   logic            grow;
   logic [XLEN-1:0] next_pc;
`endif

   always_comb begin
      found_o     = 1'b0;
      iaddr_o     = pc_i[XLEN-1:0];
      iretire_o   = '0;
      ilastsize_o = 1'b0;
      end_idx     = 0;
`ifdef MURE_MERGE_EN
      grow    = 1'b0;
      next_pc = '0;
`endif
      for (int i = 0; i < NRET; i++) begin
         if (valid_i[i] && !found_o && (i >= int'(ptr_i))) begin
            found_o     = 1'b1;
            end_idx     = i;
            iaddr_o     = pc_i[i*XLEN +: XLEN];
            iretire_o   = IRETIRE_LEN'(compressed_i[i] ? 1 : 2);
            ilastsize_o = ~compressed_i[i];
`ifdef MURE_MERGE_EN
            grow    = 1'b1;
            next_pc = pc_i[i*XLEN +: XLEN] + XLEN'(compressed_i[i] ? 2 : 4);
         end else if (found_o && grow && valid_i[i]) begin
            if (pc_i[i*XLEN +: XLEN] == next_pc) begin
               end_idx     = i;
               iretire_o   = iretire_o + IRETIRE_LEN'(compressed_i[i] ? 1 : 2);
               ilastsize_o = ~compressed_i[i];
               next_pc     = pc_i[i*XLEN +: XLEN] + XLEN'(compressed_i[i] ? 2 : 4);
            end else begin
               grow = 1'b0;
            end
`endif
         end
      end

      // Slots below the pointer were already emitted, so only look past the beat end.
      more = 1'b0;
      for (int i = 0; i < NRET; i++) begin
         if (found_o && valid_i[i] && (i > end_idx)) more = 1'b1;
      end
      last_o     = ~more;
      next_ptr_o = IDX_W'(end_idx + 1);
   end

endmodule

// File: rtl/mure_retire_serializer.sv
// Buffers per-cycle retirement rows and serialises them into trace-encoder beats.
// MURE_MERGE_EN: sequential-PC slots of a row are merged into one beat.
module mure_retire_serializer
   import mure_pkg::*;
#(
   parameter int  NRET        = 2,
   parameter int  DEPTH       = 16,
   parameter int  XLEN        = 64,
   parameter int  INST_LEN    = 32,
   localparam int IRETIRE_LEN = iretire_len(NRET)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NRET-1:0]          valid_i,
   input  logic [NRET*XLEN-1:0]     pc_i,
   input  logic [NRET*INST_LEN-1:0] inst_data_i,
   input  logic [NRET-1:0]          compressed_i,
   input  logic                     exception_i,
   input  logic                     interrupt_i,
   input  logic                     eret_i,
   input  logic [CAUSE_LEN-1:0]     cause_i,
   input  logic [XLEN-1:0]          tval_i,
   input  logic [PRIV_LEN-1:0]      priv_i,
   output logic                     ready_o,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic [IRETIRE_LEN-1:0]   iretire_o,
   output logic                     ilastsize_o,
   output logic [ITYPE_LEN-1:0]     itype_o,
   output logic [CAUSE_LEN-1:0]     cause_o,
   output logic [XLEN-1:0]          tval_o,
   output logic [PRIV_LEN-1:0]      priv_o,
   output logic [XLEN-1:0]          iaddr_o,
   output logic                     overflow_o
);

   localparam int IDX_W = (NRET > 1) ? $clog2(NRET) : 1;

   typedef struct packed {
      logic [NRET-1:0]          valid;
      logic [NRET*XLEN-1:0]     pc;
      logic [NRET*INST_LEN-1:0] inst;
      logic [NRET-1:0]          compressed;
      trap_flags_t              flags;
      logic [CAUSE_LEN-1:0]     cause;
      logic [XLEN-1:0]          tval;
      logic [PRIV_LEN-1:0]      priv;
   } row_t;

   row_t row_wr, row_rd;
   logic fifo_full, fifo_empty, fifo_push, fifo_pop, push_req;
   logic unused_inst;

   logic                   pick_found, pick_last, pick_lastsize;
   logic [XLEN-1:0]        pick_iaddr;
   logic [IRETIRE_LEN-1:0] pick_iretire;
   logic [IDX_W-1:0]       pick_next_ptr;
   itype_e                 beat_itype;

   logic                   valid_q, valid_d, ilastsize_q, ilastsize_d, overflow_q, overflow_d;
   logic [IRETIRE_LEN-1:0] iretire_q, iretire_d;
   logic [ITYPE_LEN-1:0]   itype_q, itype_d;
   logic [CAUSE_LEN-1:0]   cause_q, cause_d;
   logic [XLEN-1:0]        tval_q, tval_d, iaddr_q, iaddr_d;
   logic [PRIV_LEN-1:0]    priv_q, priv_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;

   assign push_req  = (|valid_i) | exception_i | interrupt_i | eret_i;
   assign fifo_push = push_req & ~fifo_full;
   assign ready_o   = ~fifo_full;

   always_comb begin
      row_wr.valid           = valid_i;
      row_wr.pc              = pc_i;
      row_wr.inst            = inst_data_i;
      row_wr.compressed      = compressed_i;
      row_wr.flags.interrupt = interrupt_i;
      row_wr.flags.exception = exception_i;
      row_wr.flags.eret      = eret_i;
      row_wr.cause           = cause_i;
      row_wr.tval            = tval_i;
      row_wr.priv            = priv_i;
   end

   // Instruction words are carried for downstream consumers but not encoded in beats.
   assign unused_inst = ^row_rd.inst;

   fifo_v3 #(
      .DEPTH (DEPTH),
      .dtype (row_t)
   ) u_row_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .data_i  (row_wr),
      .push_i  (fifo_push),
      .data_o  (row_rd),
      .pop_i   (fifo_pop)
   );

   mure_slot_picker #(
      .NRET        (NRET),
      .XLEN        (XLEN),
      .IDX_W       (IDX_W),
      .IRETIRE_LEN (IRETIRE_LEN)
   ) u_picker (
      .valid_i      (row_rd.valid),
      .pc_i         (row_rd.pc),
      .compressed_i (row_rd.compressed),
      .ptr_i        (ptr_q),
      .found_o      (pick_found),
      .iaddr_o      (pick_iaddr),
      .iretire_o    (pick_iretire),
      .ilastsize_o  (pick_lastsize),
      .last_o       (pick_last),
      .next_ptr_o   (pick_next_ptr)
   );

   assign beat_itype = pick_last ? flags_to_itype(row_rd.flags) : ITYPE_STD;

   // The beat register reloads only when empty or being accepted, keeping stalled beats stable.
   always_comb begin
      valid_d     = valid_q;
      iretire_d   = iretire_q;
      ilastsize_d = ilastsize_q;
      itype_d     = itype_q;
      cause_d     = cause_q;
      tval_d      = tval_q;
      priv_d      = priv_q;
      iaddr_d     = iaddr_q;
      ptr_d       = ptr_q;
      fifo_pop    = 1'b0;
      overflow_d  = overflow_q | (push_req & fifo_full);
      if (!valid_q || ready_i) begin
         valid_d = ~fifo_empty;
         if (!fifo_empty) begin
            iretire_d   = pick_found ? pick_iretire : '0;
            ilastsize_d = pick_found ? pick_lastsize : 1'b0;
            iaddr_d     = pick_iaddr;
            itype_d     = beat_itype;
            cause_d     = (beat_itype != ITYPE_STD) ? row_rd.cause : '0;
            tval_d      = (beat_itype != ITYPE_STD) ? row_rd.tval : '0;
            priv_d      = (beat_itype != ITYPE_STD) ? row_rd.priv : '0;
            if (pick_last) begin
               fifo_pop = 1'b1;
               ptr_d    = '0;
            end else begin
               ptr_d = pick_next_ptr;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q     <= 1'b0;
         iretire_q   <= '0;
         ilastsize_q <= 1'b0;
         itype_q     <= '0;
         cause_q     <= '0;
         tval_q      <= '0;
         priv_q      <= '0;
         iaddr_q     <= '0;
         ptr_q       <= '0;
         overflow_q  <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         iretire_q   <= iretire_d;
         ilastsize_q <= ilastsize_d;
         itype_q     <= itype_d;
         cause_q     <= cause_d;
         tval_q      <= tval_d;
         priv_q      <= priv_d;
         iaddr_q     <= iaddr_d;
         ptr_q       <= ptr_d;
         overflow_q  <= overflow_d;
      end
   end

   assign valid_o     = valid_q;
   assign iretire_o   = iretire_q;
   assign ilastsize_o = ilastsize_q;
   assign itype_o     = itype_q;
   assign cause_o     = cause_q;
   assign tval_o      = tval_q;
   assign priv_o      = priv_q;
   assign iaddr_o     = iaddr_q;
   assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_mure_retire_serializer.sv
// Scoreboard bench for mure_retire_serializer (NRET=2, DEPTH=16); honours MURE_MERGE_EN.
module tb_mure_retire_serializer;

   logic         clk = 1'b0;
   logic         rst_i;
   logic [1:0]   valid_i;
   logic [127:0] pc_i;
   logic [63:0]  inst_data_i;
   logic [1:0]   compressed_i;
   logic         exception_i, interrupt_i, eret_i;
   logic [4:0]   cause_i;
   logic [63:0]  tval_i;
   logic [1:0]   priv_i;
   logic         ready_o, valid_o, ready_i;
   logic [3:0]   iretire_o;
   logic         ilastsize_o;
   logic [2:0]   itype_o;
   logic [4:0]   cause_o;
   logic [63:0]  tval_o;
   logic [1:0]   priv_o;
   logic [63:0]  iaddr_o;
   logic         overflow_o;

   typedef struct packed {
      logic [63:0] iaddr;
      logic [3:0]  iretire;
      logic        ilastsize;
      logic [2:0]  itype;
      logic [4:0]  cause;
      logic [63:0] tval;
      logic [1:0]  priv;
   } beat_t;

   beat_t exp_q[$];
   beat_t act_b, exp_b;
   int    n_checks = 0;
   int    n_fail   = 0;

   mure_retire_serializer #(.NRET(2), .DEPTH(16), .XLEN(64), .INST_LEN(32)) dut (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .pc_i(pc_i), .inst_data_i(inst_data_i),
      .compressed_i(compressed_i), .exception_i(exception_i), .interrupt_i(interrupt_i),
      .eret_i(eret_i), .cause_i(cause_i), .tval_i(tval_i), .priv_i(priv_i), .ready_o(ready_o),
      .valid_o(valid_o), .ready_i(ready_i), .iretire_o(iretire_o), .ilastsize_o(ilastsize_o),
      .itype_o(itype_o), .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o), .iaddr_o(iaddr_o),
      .overflow_o(overflow_o)
   );

   always #5 clk = ~clk;

   // Monitor: every accepted beat is checked against the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst_i && valid_o && ready_i) begin
         act_b = {iaddr_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o};
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL beat_unexpected: got iaddr=%h iretire=%0d itype=%0d, expected no beat",
                     act_b.iaddr, act_b.iretire, act_b.itype);
         end else begin
            exp_b = exp_q.pop_front();
            if (act_b !== exp_b) begin
               n_fail++;
               $display("FAIL beat: got iaddr=%h iret=%0d lsz=%0d itype=%0d cause=%0d tval=%h priv=%0d, expected iaddr=%h iret=%0d lsz=%0d itype=%0d cause=%0d tval=%h priv=%0d",
                        act_b.iaddr, act_b.iretire, act_b.ilastsize, act_b.itype, act_b.cause, act_b.tval, act_b.priv,
                        exp_b.iaddr, exp_b.iretire, exp_b.ilastsize, exp_b.itype, exp_b.cause, exp_b.tval, exp_b.priv);
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_beat(input logic [63:0] addr, input logic [3:0] iret, input logic lsz,
                              input logic [2:0] ity, input logic [4:0] cause, input logic [63:0] tval,
                              input logic [1:0] priv);
      beat_t b;
      b = {addr, iret, lsz, ity, cause, tval, priv};
      exp_q.push_back(b);
   endtask

   // flags = {interrupt, exception, eret}
   task automatic drive_row(input logic [1:0] v, input logic [63:0] p0, input logic [63:0] p1,
                            input logic [1:0] c, input logic [2:0] flags, input logic [4:0] cause,
                            input logic [63:0] tval, input logic [1:0] priv);
      valid_i      = v;
      pc_i         = {p1, p0};
      inst_data_i  = {32'h0000_0013, 32'h0000_0013};
      compressed_i = c;
      interrupt_i  = flags[2];
      exception_i  = flags[1];
      eret_i       = flags[0];
      cause_i      = cause;
      tval_i       = tval;
      priv_i       = priv;
      @(posedge clk);
      #1;
      valid_i     = 2'b00;
      interrupt_i = 1'b0;
      exception_i = 1'b0;
      eret_i      = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0 && !valid_o) break;
         @(posedge clk);
         #1;
      end
      check(name, 64'(exp_q.size()) | 64'(valid_o), 64'd0);
   endtask

   initial begin
      rst_i = 1'b1; ready_i = 1'b0; valid_i = '0; pc_i = '0; inst_data_i = '0; compressed_i = '0;
      exception_i = 1'b0; interrupt_i = 1'b0; eret_i = 1'b0; cause_i = '0; tval_i = '0; priv_i = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_i = 1'b0;

      check("rst_valid_o", 64'(valid_o), 64'd0);
      check("rst_ready_o", 64'(ready_o), 64'd1);
      check("rst_overflow_o", 64'(overflow_o), 64'd0);
      check("rst_outputs", {iaddr_o[31:0], 20'(iretire_o), 3'(itype_o), 5'(cause_o), 2'(priv_o), 2'(ilastsize_o)}, 64'd0);

      // Two sequential uncompressed slots, plus first-beat latency.
      ready_i = 1'b1;
`ifdef MURE_MERGE_EN
      expect_beat(64'h100, 4'd4, 1'b1, 3'd0, 5'd0, 64'h0, 2'd0);
`else
      expect_beat(64'h100, 4'd2, 1'b1, 3'd0, 5'd0, 64'h0, 2'd0);
      expect_beat(64'h104, 4'd2, 1'b1, 3'd0, 5'd0, 64'h0, 2'd0);
`endif
      drive_row(2'b11, 64'h100, 64'h104, 2'b00, 3'b000, 5'd0, 64'h0, 2'd0);
      check("latency_t1_valid", 64'(valid_o), 64'd0);
      @(posedge clk);
      #1;
      check("latency_t2_valid", 64'(valid_o), 64'd1);
      wait_drain("drain_seq", 20);

      // Trap rows issued back to back.
      expect_beat(64'h208, 4'd2, 1'b1, 3'd1, 5'd2, 64'hdead, 2'd3);
      drive_row(2'b10, 64'h204, 64'h208, 2'b00, 3'b010, 5'd2, 64'hdead, 2'd3);
      expect_beat(64'h200, 4'd0, 1'b0, 3'd2, 5'd7, 64'h55, 2'd1);
      drive_row(2'b00, 64'h200, 64'h0, 2'b00, 3'b100, 5'd7, 64'h55, 2'd1);
      expect_beat(64'h600, 4'd1, 1'b0, 3'd2, 5'd3, 64'h77, 2'd2);
      drive_row(2'b01, 64'h600, 64'h0, 2'b01, 3'b111, 5'd3, 64'h77, 2'd2);
      expect_beat(64'h800, 4'd2, 1'b1, 3'd1, 5'd4, 64'h44, 2'd3);
      drive_row(2'b01, 64'h800, 64'h0, 2'b00, 3'b011, 5'd4, 64'h44, 2'd3);
`ifdef MURE_MERGE_EN
      expect_beat(64'h700, 4'd4, 1'b1, 3'd3, 5'd9, 64'h99, 2'd0);
`else
      expect_beat(64'h700, 4'd2, 1'b1, 3'd0, 5'd0, 64'h0, 2'd0);
      expect_beat(64'h704, 4'd2, 1'b1, 3'd3, 5'd9, 64'h99, 2'd0);
`endif
      drive_row(2'b11, 64'h700, 64'h704, 2'b00, 3'b001, 5'd9, 64'h99, 2'd0);
      expect_beat(64'h400, 4'd1, 1'b0, 3'd0, 5'd0, 64'h0, 2'd0);
      expect_beat(64'h500, 4'd1, 1'b0, 3'd0, 5'd0, 64'h0, 2'd0);
      drive_row(2'b11, 64'h400, 64'h500, 2'b11, 3'b000, 5'd0, 64'h0, 2'd0);
      wait_drain("drain_traps", 40);

      // Compressed followed by sequential uncompressed, then non-sequential.
`ifdef MURE_MERGE_EN
      expect_beat(64'h100, 4'd3, 1'b1, 3'd0, 5'd0, 64'h0, 2'd0);
`else
      expect_beat(64'h100, 4'd1, 1'b0, 3'd0, 5'd0, 64'h0, 2'd0);
      expect_beat(64'h102, 4'd2, 1'b1, 3'd0, 5'd0, 64'h0, 2'd0);
`endif
      drive_row(2'b11, 64'h100, 64'h102, 2'b01, 3'b000, 5'd0, 64'h0, 2'd0);
      expect_beat(64'h100, 4'd1, 1'b0, 3'd0, 5'd0, 64'h0, 2'd0);
      expect_beat(64'h300, 4'd2, 1'b1, 3'd0, 5'd0, 64'h0, 2'd0);
      drive_row(2'b11, 64'h100, 64'h300, 2'b01, 3'b000, 5'd0, 64'h0, 2'd0);
      wait_drain("drain_merge", 20);

      // Stall: one held beat, then 17 rows against 16 FIFO entries.
      ready_i = 1'b0;
      expect_beat(64'hf00, 4'd2, 1'b1, 3'd0, 5'd0, 64'h0, 2'd0);
      drive_row(2'b01, 64'hf00, 64'h0, 2'b00, 3'b000, 5'd0, 64'h0, 2'd0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 17; i++) begin
         if (i < 16) expect_beat(64'h1000 + 64'(i) * 64'h10, 4'd2, 1'b1, 3'd0, 5'd0, 64'h0, 2'd0);
         if (i == 16) check("overflow_before_drop", 64'(overflow_o), 64'd0);
         drive_row(2'b01, 64'h1000 + 64'(i) * 64'h10, 64'h0, 2'b00, 3'b000, 5'd0, 64'h0, 2'd0);
         check("held_iaddr", iaddr_o, 64'hf00);
         if (i == 14) check("ready_o_15_rows", 64'(ready_o), 64'd1);
         if (i == 15) check("ready_o_full", 64'(ready_o), 64'd0);
      end
      check("overflow_set", 64'(overflow_o), 64'd1);
      check("held_valid", 64'(valid_o), 64'd1);
      ready_i = 1'b1;
      wait_drain("drain_overflow", 60);
      check("overflow_sticky", 64'(overflow_o), 64'd1);

      // Reset with a held beat and three buffered rows.
      ready_i = 1'b0;
      for (int i = 0; i < 4; i++)
         drive_row(2'b01, 64'h2000 + 64'(i) * 64'h4, 64'h0, 2'b00, 3'b000, 5'd0, 64'h0, 2'd0);
      @(posedge clk);
      #1;
      check("prereset_valid", 64'(valid_o), 64'd1);
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      check("postreset_valid", 64'(valid_o), 64'd0);
      check("postreset_ready", 64'(ready_o), 64'd1);
      check("postreset_overflow", 64'(overflow_o), 64'd0);
      ready_i = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("postreset_idle", 64'(valid_o), 64'd0);
      expect_beat(64'h3000, 4'd1, 1'b0, 3'd0, 5'd0, 64'h0, 2'd0);
      drive_row(2'b01, 64'h3000, 64'h0, 2'b01, 3'b000, 5'd0, 64'h0, 2'd0);
      wait_drain("drain_postreset", 20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "watchdog expired");
   end

endmodule
